// File: rtl/instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// instruction_fetch_stage
// IF stage of the 5-stage MIPS pipeline: PC register, instruction memory with a
// debug write port, and the IF/ID pipeline register. A three-state controller
// (IDLE / RUN / HALTED) gates fetch: the program is loaded in IDLE, fetched in
// RUN until a HALT word reaches IF/ID, then the pipeline drains in HALTED.
//
// Optional feature macro: IF_STAGE_STEP_EN
//   defined   -> in RUN, PC and IF/ID only advance on cycles with i_step=1
//   undefined -> i_step is ignored and fetch is free-running
// -----------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_prog_we,
    input  logic [31:0] i_prog_addr,
    input  logic [31:0] i_prog_data,
    input  logic        i_start,
    input  logic        i_clear,
    input  logic        i_step,
    input  logic        i_pc_write,
    input  logic        i_if_id_write,
    input  logic        i_jump_taken,
    input  logic [31:0] i_jump_addr,
    input  logic        i_flush,
    output logic [31:0] o_pc,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc4,
    output logic        o_if_id_valid,
    output logic        o_halted,
    output logic [1:0]  o_state
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    // Instruction memory: written by the debug port, read combinationally by fetch.
    logic [31:0]   r_imem [IMEM_DEPTH];

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_next;
    logic [31:0]   r_if_id_instr;
    logic [31:0]   w_if_id_instr_next;
    logic [31:0]   r_if_id_pc4;
    logic [31:0]   w_if_id_pc4_next;
    logic          r_if_id_valid;
    logic          w_if_id_valid_next;

    logic [31:0]   w_pc_plus4;
    logic [31:0]   w_imem_rdata;
    logic [AW-1:0] w_prog_idx;
    logic [AW-1:0] w_fetch_idx;
    logic          w_mem_we;
    logic          w_step;
    logic          w_pc_en;
    logic          w_if_id_en;
    logic          w_halt_load;
    logic          w_unused_ok;

`ifdef IF_STAGE_STEP_EN
    assign w_step      = i_step;
    assign w_unused_ok = ^{i_prog_addr[1:0], i_prog_addr[31:AW+2]};
`else
    assign w_step      = 1'b1;
    assign w_unused_ok = ^{i_step, i_prog_addr[1:0], i_prog_addr[31:AW+2]};
`endif

    // Word index drops the byte offset and any bits beyond the memory size,
    // so out-of-range addresses alias back into the array.
    assign w_prog_idx   = i_prog_addr[AW+1:2];
    assign w_fetch_idx  = r_pc[AW+1:2];
    assign w_imem_rdata = r_imem[w_fetch_idx];
    assign w_pc_plus4   = r_pc + 32'd4;

    // The program can only be changed while fetch is idle.
    assign w_mem_we     = (r_state == ST_IDLE) && i_prog_we;

    // Hazard-unit enables, optionally qualified by the single-step strobe.
    assign w_pc_en      = i_pc_write && w_step;
    assign w_if_id_en   = i_if_id_write && w_step;

    // A HALT word actually being captured into IF/ID (not stalled, not flushed).
    assign w_halt_load  = (r_state == ST_RUN) && w_if_id_en && !i_flush &&
                          (w_imem_rdata == HALT_WORD);

    // Memory write port; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_imem[w_prog_idx] <= i_prog_data;
        end
    end

    // Controller state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Controller next-state: start only when no write competes, halt on a
    // captured HALT word, clear returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_prog_we) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_halt_load) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (i_clear) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Controller outputs.
    always_comb begin
        o_state  = r_state;
        o_halted = (r_state == ST_HALTED);
    end

    // PC next value: stall holds (and drops any jump), redirect beats
    // sequential fetch, and PC parks on the HALT word once it is captured.
    always_comb begin
        w_pc_next = r_pc;
        case (r_state)
            ST_RUN: begin
                if (w_pc_en && !w_halt_load) begin
                    w_pc_next = i_jump_taken ? i_jump_addr : w_pc_plus4;
                end
            end
            ST_HALTED: begin
                if (i_clear) begin
                    w_pc_next = RESET_PC;
                end
            end
            default: begin
                w_pc_next = r_pc;
            end
        endcase
    end

    // IF/ID next value: stall wins over flush; in HALTED every enabled cycle
    // inserts a bubble so downstream stages drain.
    always_comb begin
        w_if_id_instr_next = r_if_id_instr;
        w_if_id_pc4_next   = r_if_id_pc4;
        w_if_id_valid_next = r_if_id_valid;
        case (r_state)
            ST_RUN: begin
                if (w_if_id_en) begin
                    if (i_flush) begin
                        w_if_id_instr_next = 32'h0;
                        w_if_id_pc4_next   = 32'h0;
                        w_if_id_valid_next = 1'b0;
                    end else begin
                        w_if_id_instr_next = w_imem_rdata;
                        w_if_id_pc4_next   = w_pc_plus4;
                        w_if_id_valid_next = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (i_clear || i_if_id_write) begin
                    w_if_id_instr_next = 32'h0;
                    w_if_id_pc4_next   = 32'h0;
                    w_if_id_valid_next = 1'b0;
                end
            end
            default: begin
                w_if_id_valid_next = r_if_id_valid;
            end
        endcase
    end

    // PC and IF/ID registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc          <= RESET_PC;
            r_if_id_instr <= 32'h0;
            r_if_id_pc4   <= 32'h0;
            r_if_id_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_if_id_instr <= w_if_id_instr_next;
            r_if_id_pc4   <= w_if_id_pc4_next;
            r_if_id_valid <= w_if_id_valid_next;
        end
    end

    assign o_pc          = r_pc;
    assign o_if_id_instr = r_if_id_instr;
    assign o_if_id_pc4   = r_if_id_pc4;
    assign o_if_id_valid = r_if_id_valid;

endmodule
